// File: rtl/ddc_ctrl_pkg.sv
// Shared types and default constants for the receive DDC frame sequencer.
package ddc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    CAPTURE = 3'd2,
    RUN     = 3'd3,
    FLUSH   = 3'd4
  } ddc_state_e;

  localparam int                DDC_FRAME_LEN    = 680;
  localparam logic signed [15:0] DDC_MARKER_PHASE = -16'sd6559;

endpackage

// File: rtl/ddc_valid_delay.sv
// DEPTH-stage shift line carrying {valid, last} alongside the mixer pipeline.
module ddc_valid_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;

  always_comb begin
    valid_d = (valid_q << 1) | DEPTH'(in_valid);
    last_d  = (last_q << 1) | DEPTH'(in_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/ddc_frame_ctrl.sv
// Receive DDC sequencer: LUT capture, I/Q beat join, read addressing, aligned valid/last.
// Define DDC_FRAME_STATS_EN to build the completed-frame counter on frame_cnt.
module ddc_frame_ctrl
  import ddc_ctrl_pkg::*;
#(
  parameter int                FRAME_LEN    = DDC_FRAME_LEN,
  parameter logic signed [15:0] MARKER_PHASE = DDC_MARKER_PHASE,
  parameter int                PIPE_LAT     = 3,
  parameter int                SKEW_MAX     = 4,
  parameter int                AW           = 10
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cfg_start,
  input  logic                cfg_stop,
  input  logic                vco_phase_valid,
  input  logic signed [15:0]  vco_phase,
  output logic                lut_wr_en,
  output logic [AW-1:0]       lut_wr_addr,
  input  logic                s_tvalid_I,
  input  logic                s_tvalid_Q,
  input  logic                s_tlast_I,
  input  logic                s_tlast_Q,
  output logic                s_tready,
  input  logic                ds_tready,
  output logic [AW-1:0]       lut_rd_addr,
  output logic                m_tvalid,
  output logic                m_tlast,
  output logic                busy,
  output logic                err_tlast,
  output logic                err_iq_skew,
  output logic [31:0]         frame_cnt,
  output ddc_state_e          dbg_state
);

  localparam int              SW        = $clog2(SKEW_MAX + 2);
  localparam int              FW        = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(FRAME_LEN - 1);
  localparam logic [SW-1:0]   SKEW_LIM  = SW'(SKEW_MAX);
  localparam logic [SW-1:0]   SKEW_SAT  = SW'(SKEW_MAX + 1);
  localparam logic [FW-1:0]   FLUSH_END = FW'(PIPE_LAT - 1);

  ddc_state_e    state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [SW-1:0] skew_cnt_q, skew_cnt_d;
  logic          stop_pend_q, stop_pend_d;
  logic          err_tlast_q, err_tlast_d;
  logic          err_iq_skew_q, err_iq_skew_d;
  logic          busy_q, busy_d;

  logic start_ok, accept, frame_end, wr_fire;

  // Handshake: s_tready is asserted only when both I and Q present a beat and
  // the output FIFO can take it, so the two streams always transfer together.
  assign start_ok  = (state_q == IDLE) && cfg_start && !cfg_stop;
  assign accept    = (state_q == RUN) && s_tvalid_I && s_tvalid_Q && ds_tready;
  assign frame_end = (rd_addr_q == LAST_ADDR);
  assign wr_fire   = (state_q == CAPTURE) && vco_phase_valid && !cfg_stop;

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    flush_cnt_d   = flush_cnt_q;
    skew_cnt_d    = '0;
    stop_pend_d   = stop_pend_q;
    err_tlast_d   = err_tlast_q;
    err_iq_skew_d = err_iq_skew_q;
    if (start_ok) begin
      err_tlast_d   = 1'b0;
      err_iq_skew_d = 1'b0;
    end
    case (state_q)
      IDLE: if (start_ok) state_d = ARM;
      ARM: begin
        if (cfg_stop) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
        end else if (vco_phase_valid && (vco_phase == MARKER_PHASE)) begin
          state_d   = CAPTURE;
          wr_addr_d = '0;
        end
      end
      CAPTURE: begin
        if (cfg_stop) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
        end else if (wr_fire) begin
          if (wr_addr_q == LAST_ADDR) begin
            state_d   = RUN;
            rd_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (cfg_stop) stop_pend_d = 1'b1;
        if (s_tvalid_I != s_tvalid_Q)
          skew_cnt_d = (skew_cnt_q == SKEW_SAT) ? skew_cnt_q : skew_cnt_q + 1'b1;
        if (skew_cnt_d > SKEW_LIM) err_iq_skew_d = 1'b1;
        if (accept) begin
          // An early tlast still resyncs the read address to the frame start.
          rd_addr_d = (frame_end || s_tlast_I) ? '0 : rd_addr_q + 1'b1;
          if ((s_tlast_I != s_tlast_Q) || (s_tlast_I != frame_end)) err_tlast_d = 1'b1;
          if (frame_end && stop_pend_q) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_END) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      flush_cnt_q   <= '0;
      skew_cnt_q    <= '0;
      stop_pend_q   <= 1'b0;
      err_tlast_q   <= 1'b0;
      err_iq_skew_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      flush_cnt_q   <= flush_cnt_d;
      skew_cnt_q    <= skew_cnt_d;
      stop_pend_q   <= stop_pend_d;
      err_tlast_q   <= err_tlast_d;
      err_iq_skew_q <= err_iq_skew_d;
      busy_q        <= busy_d;
    end
  end

`ifdef DDC_FRAME_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (start_ok) frame_cnt_d = '0;
    else if (accept && frame_end && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

  ddc_valid_delay #(.DEPTH(PIPE_LAT)) u_delay (
    .clk       (aclk),
    .rst_n     (aresetn),
    .in_valid  (accept),
    .in_last   (accept && frame_end),
    .out_valid (m_tvalid),
    .out_last  (m_tlast)
  );

  assign lut_wr_en   = wr_fire;
  assign lut_wr_addr = wr_addr_q;
  assign s_tready    = accept;
  assign lut_rd_addr = rd_addr_q;
  assign busy        = busy_q;
  assign err_tlast   = err_tlast_q;
  assign err_iq_skew = err_iq_skew_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ddc_frame_ctrl.sv
// Directed bench for ddc_frame_ctrl: vector table plus multi-cycle sequences and a cycle monitor.
module tb_ddc_frame_ctrl;
  import ddc_ctrl_pkg::*;

  localparam int FRAME_LEN = 680;
  localparam int MARKER    = -6559;

  logic               aclk, aresetn;
  logic               cfg_start, cfg_stop;
  logic               vco_phase_valid;
  logic signed [15:0] vco_phase;
  logic               lut_wr_en;
  logic [9:0]         lut_wr_addr;
  logic               s_tvalid_I, s_tvalid_Q, s_tlast_I, s_tlast_Q;
  logic               s_tready, ds_tready;
  logic [9:0]         lut_rd_addr;
  logic               m_tvalid, m_tlast, busy, err_tlast, err_iq_skew;
  logic [31:0]        frame_cnt;
  ddc_state_e         dbg_state;

  ddc_frame_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .vco_phase_valid(vco_phase_valid), .vco_phase(vco_phase),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr),
    .s_tvalid_I(s_tvalid_I), .s_tvalid_Q(s_tvalid_Q),
    .s_tlast_I(s_tlast_I), .s_tlast_Q(s_tlast_Q),
    .s_tready(s_tready), .ds_tready(ds_tready), .lut_rd_addr(lut_rd_addr),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .busy(busy),
    .err_tlast(err_tlast), .err_iq_skew(err_iq_skew),
    .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [1:0] exp_q[$];
  bit  tb_run = 1'b0;
  bit  tb_cap = 1'b0;
  int  model_rd = 0;
  int  wr_count = 0;
  int  wr_pulses = 0;
  int  mtv_cnt = 0;
  int  mtl_cnt = 0;

  always @(negedge aclk) begin
    logic       exp_acc, exp_wr, fe;
    logic [1:0] exp_vl;
    if (!aresetn) begin
      exp_q.delete();
      repeat (3) exp_q.push_back(2'b00);
      model_rd = 0;
    end else begin
      exp_acc = tb_run && s_tvalid_I && s_tvalid_Q && ds_tready;
      exp_wr  = tb_cap && vco_phase_valid && !cfg_stop;
      chk("s_tready", 32'(s_tready), 32'(exp_acc));
      chk("lut_wr_en", 32'(lut_wr_en), 32'(exp_wr));
      if (lut_wr_en) wr_pulses++;
      if (exp_wr) begin
        chk("lut_wr_addr", 32'(lut_wr_addr), 32'(wr_count));
        wr_count++;
      end
      chk("lut_rd_addr", 32'(lut_rd_addr), 32'(model_rd));
      exp_vl = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
      chk("m_tvalid", 32'(m_tvalid), 32'(exp_vl[1]));
      chk("m_tlast", 32'(m_tlast), 32'(exp_vl[0]));
      if (m_tvalid) mtv_cnt++;
      if (m_tlast) mtl_cnt++;
      fe = (model_rd == FRAME_LEN - 1);
      exp_q.push_back({exp_acc, exp_acc && fe});
      if (exp_acc) model_rd = (fe || s_tlast_I) ? 0 : model_rd + 1;
    end
  end

  // ---------------- driver tasks ----------------
  int ph;

  task automatic arm_and_mark();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wr_count  = 0;
    wr_pulses = 0;
    for (int i = 0; i <= 20; i++) begin
      ph = MARKER - 20 + i;
      vco_phase_valid = 1'b1;
      vco_phase = 16'(ph);
      tick();
    end
    tb_cap = 1'b1;
  endtask

  task automatic do_capture();
    int n = 0;
    int c = 0;
    arm_and_mark();
    while (n < FRAME_LEN) begin
      vco_phase_valid = (c % 9 != 8);
      ph++;
      vco_phase = 16'(ph);
      tick();
      if (vco_phase_valid) n++;
      c++;
    end
    tb_cap = 1'b0;
    tb_run = 1'b1;
    repeat (3) begin
      ph++;
      vco_phase = 16'(ph);
      tick();
    end
    vco_phase_valid = 1'b0;
    chk("capture_pulses", 32'(wr_pulses), 32'(FRAME_LEN));
  endtask

  task automatic beats(input int n);
    int got = 0;
    while (got < n) begin
      s_tvalid_I = 1'b1;
      s_tvalid_Q = 1'b1;
      ds_tready  = 1'b1;
      s_tlast_I  = (model_rd == FRAME_LEN - 1);
      s_tlast_Q  = s_tlast_I;
      tick();
      got++;
    end
    s_tvalid_I = 1'b0;
    s_tvalid_Q = 1'b0;
    s_tlast_I  = 1'b0;
    s_tlast_Q  = 1'b0;
  endtask

  // Q leads I by lag cycles on both edges of an 8-cycle overlap; ds_tready toggles.
  task automatic skew_burst(input int lag);
    for (int k = 0; k < lag + 8 + lag; k++) begin
      s_tvalid_Q = (k < lag + 8);
      s_tvalid_I = (k >= lag);
      ds_tready  = k[0];
      s_tlast_I  = (model_rd == FRAME_LEN - 1);
      s_tlast_Q  = s_tlast_I;
      tick();
    end
    s_tvalid_I = 1'b0;
    s_tvalid_Q = 1'b0;
    s_tlast_I  = 1'b0;
    s_tlast_Q  = 1'b0;
    ds_tready  = 1'b1;
    repeat (2) tick();
  endtask

  task automatic stop_run();
    cfg_stop = 1'b1;
    beats(1);
    cfg_stop = 1'b0;
    beats(FRAME_LEN - model_rd);
    tb_run = 1'b0;
    repeat (6) tick();
    chk("stop_run_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       vi;
    logic       vq;
    logic       ds;
    logic       exp_rdy;
    logic [9:0] exp_rd;
  } vec_t;
  vec_t tbl[8];

  logic [31:0] exp_fc;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'd1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 10'd1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd2};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd3};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd3};

    aresetn = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0;
    vco_phase_valid = 1'b0; vco_phase = '0;
    s_tvalid_I = 1'b0; s_tvalid_Q = 1'b0; s_tlast_I = 1'b0; s_tlast_Q = 1'b0;
    ds_tready = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_rd_addr", 32'(lut_rd_addr), 32'd0);
    chk("rst_errs", 32'({err_tlast, err_iq_skew}), 32'd0);
    chk("rst_frame_cnt", frame_cnt, 32'd0);
    aresetn = 1'b1;
    tick();

    // Start and stop together: stop wins
    cfg_start = 1'b1; cfg_stop = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    chk("start_stop_idle", 32'(dbg_state), 32'(IDLE));

    // Stop while armed
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("armed", 32'(dbg_state), 32'(ARM));
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    chk("arm_stop_busy", 32'(busy), 32'd0);

    // Stop while capturing: no write on the stop cycle
    arm_and_mark();
    chk("capturing", 32'(dbg_state), 32'(CAPTURE));
    repeat (10) begin
      ph++;
      vco_phase = 16'(ph);
      tick();
    end
    cfg_stop = 1'b1;
    #1;
    chk("cap_stop_no_wr", 32'(lut_wr_en), 32'd0);
    tick();
    cfg_stop = 1'b0;
    tb_cap = 1'b0;
    vco_phase_valid = 1'b0;
    chk("cap_stop_state", 32'(dbg_state), 32'(IDLE));

    // Full capture into RUN
    do_capture();
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_state", 32'(dbg_state), 32'(RUN));

    // Handshake vectors
    for (int i = 0; i < 8; i++) begin
      s_tvalid_I = tbl[i].vi;
      s_tvalid_Q = tbl[i].vq;
      ds_tready  = tbl[i].ds;
      #1;
      chk("vec_ready", 32'(s_tready), 32'(tbl[i].exp_rdy));
      tick();
      chk("vec_rd_addr", 32'(lut_rd_addr), 32'(tbl[i].exp_rd));
    end
    ds_tready = 1'b1;
    beats(FRAME_LEN - model_rd);
    chk("err_tlast_after_vec", 32'(err_tlast), 32'd0);

    // Two full frames
    s_tvalid_I = 1'b0; s_tvalid_Q = 1'b0;
    repeat (4) tick();
    mtv_cnt = 0;
    mtl_cnt = 0;
    beats(2 * FRAME_LEN);
    repeat (4) tick();
    chk("two_frame_valids", 32'(mtv_cnt), 32'd1360);
    chk("two_frame_lasts", 32'(mtl_cnt), 32'd2);
    chk("two_frame_err_tlast", 32'(err_tlast), 32'd0);

    // Skew under backpressure
    skew_burst(2);
    chk("skew2_no_err", 32'(err_iq_skew), 32'd0);
    skew_burst(6);
    chk("skew6_err", 32'(err_iq_skew), 32'd1);

    // Early tlast at beat 400
    beats((399 - model_rd + FRAME_LEN) % FRAME_LEN);
    s_tvalid_I = 1'b1; s_tvalid_Q = 1'b1; ds_tready = 1'b1;
    s_tlast_I = 1'b1; s_tlast_Q = 1'b1;
    tick();
    s_tvalid_I = 1'b0; s_tvalid_Q = 1'b0; s_tlast_I = 1'b0; s_tlast_Q = 1'b0;
    chk("early_tlast_rd0", 32'(lut_rd_addr), 32'd0);
    chk("early_tlast_err", 32'(err_tlast), 32'd1);
    beats(1);
    stop_run();

    // Stop at beat 100 of a fresh run
    do_capture();
    chk("start_clears_errs", 32'({err_tlast, err_iq_skew}), 32'd0);
    chk("start_clears_fc", frame_cnt, 32'd0);
    beats(99);
    cfg_stop = 1'b1;
    beats(1);
    cfg_stop = 1'b0;
    beats(580);
    tb_run = 1'b0;
    s_tvalid_I = 1'b1; s_tvalid_Q = 1'b1; ds_tready = 1'b1;
    chk("flush_entry", 32'(dbg_state), 32'(FLUSH));
    tick();
    tick();
    chk("flush_busy_hold", 32'(busy), 32'd1);
    tick();
    chk("flush_busy_drop", 32'(busy), 32'd0);
`ifdef DDC_FRAME_STATS_EN
    exp_fc = 32'd1;
`else
    exp_fc = 32'd0;
`endif
    chk("stop_frame_cnt", frame_cnt, exp_fc);
    s_tvalid_I = 1'b0; s_tvalid_Q = 1'b0;
    repeat (4) tick();

    // Asynchronous reset mid-frame
    do_capture();
    beats(50);
    s_tvalid_I = 1'b1; s_tvalid_Q = 1'b1; ds_tready = 1'b1;
    #2;
    aresetn = 1'b0;
    tb_run = 1'b0;
    #1;
    chk("arst_ready", 32'(s_tready), 32'd0);
    chk("arst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd_addr", 32'(lut_rd_addr), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    tick();
    aresetn = 1'b1;
    mtv_cnt = 0;
    mtl_cnt = 0;
    repeat (10) tick();
    chk("post_rst_no_valid", 32'(mtv_cnt), 32'd0);
    chk("post_rst_no_last", 32'(mtl_cnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    s_tvalid_I = 1'b0; s_tvalid_Q = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
